wbu_arb: RTL and testbench

WBU_ARB -- requirements
Module: wbu_arb

---
 rtl/wbu_arb.sv | 119 +++++++++++
 tb/tb_wbu_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wbu_arb.sv
// wbu_arb: writeback arbiter merging the in-order ls/wb pipeline writeback and
// out-of-order multi-cycle MUL/DIV results onto one registered regfile write port.
//
// Ports
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_lsu_rdwen/rdid/rd              pipeline writeback request
//   o_lsu_stall                      holds the ls/wb stage for one cycle on starvation
//   i_mdu_valid/rdid/rd, o_mdu_ready MDU result handshake into the result buffer
//   i_idu_rs1id/rs2id, o_idu_busy    decode-stage hazard check against buffered results
//   o_wbu_rdwen/rdid/rd              registered regfile write port (also bypass source)
module wbu_arb #(
  parameter int DEPTH     = 2,
  parameter int AGE_MAX   = 3,
  parameter int REG_ADDRW = 5,
  parameter int CPU_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_lsu_rdwen,
  input  logic [REG_ADDRW-1:0] i_lsu_rdid,
  input  logic [CPU_WIDTH-1:0] i_lsu_rd,
  output logic                 o_lsu_stall,
  input  logic                 i_mdu_valid,
  output logic                 o_mdu_ready,
  input  logic [REG_ADDRW-1:0] i_mdu_rdid,
  input  logic [CPU_WIDTH-1:0] i_mdu_rd,
  input  logic [REG_ADDRW-1:0] i_idu_rs1id,
  input  logic [REG_ADDRW-1:0] i_idu_rs2id,
  output logic                 o_idu_busy,
  output logic                 o_wbu_rdwen,
  output logic [REG_ADDRW-1:0] o_wbu_rdid,
  output logic [CPU_WIDTH-1:0] o_wbu_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic [2:0]           age;
  logic [DEPTH-1:0]     ent_vld;
  logic [REG_ADDRW-1:0] ent_id   [DEPTH];
  logic [CPU_WIDTH-1:0] ent_data [DEPTH];

  logic lsu_wr, push, store, pop, empty;

  assign empty       = (count == '0);
  // Ready and stall depend on registered state only, so the MDU and pipeline
  // handshakes never form a combinational loop through this block.
  assign o_mdu_ready = (count < CW'(DEPTH));
  assign o_lsu_stall = !empty && (age == 3'(AGE_MAX));

  assign lsu_wr = i_lsu_rdwen && (i_lsu_rdid != '0) && !o_lsu_stall;
  assign push   = i_mdu_valid && o_mdu_ready;
  // Results targeting x0 are acknowledged but never occupy an entry.
  assign store  = push && (i_mdu_rdid != '0);
  assign pop    = !empty && !lsu_wr;

  always_comb begin
    o_idu_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] &&
          (((i_idu_rs1id != '0) && (ent_id[i] == i_idu_rs1id)) ||
           ((i_idu_rs2id != '0) && (ent_id[i] == i_idu_rs2id))))
        o_idu_busy = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      age     <= '0;
      ent_vld <= '0;
    end else begin
      if (store) wptr <= wptr + PW'(1);
      if (pop)   rptr <= rptr + PW'(1);
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Pop clears before store sets, so a full wrap onto the same slot keeps it valid.
      if (pop)   ent_vld[rptr] <= 1'b0;
      if (store) ent_vld[wptr] <= 1'b1;
      if (empty || pop)
        age <= '0;
      else if (age != 3'(AGE_MAX))
        age <= age + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (store) begin
      ent_id[wptr]   <= i_mdu_rdid;
      ent_data[wptr] <= i_mdu_rd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wbu_rdwen <= 1'b0;
      o_wbu_rdid  <= '0;
      o_wbu_rd    <= '0;
    end else if (lsu_wr) begin
      o_wbu_rdwen <= 1'b1;
      o_wbu_rdid  <= i_lsu_rdid;
      o_wbu_rd    <= i_lsu_rd;
    end else if (pop) begin
      o_wbu_rdwen <= 1'b1;
      o_wbu_rdid  <= ent_id[rptr];
      o_wbu_rd    <= ent_data[rptr];
    end else begin
      o_wbu_rdwen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wbu_arb.sv
module tb_wbu_arb;
  localparam int DEPTH   = 2;
  localparam int AGE_MAX = 3;
  localparam int AW      = 5;
  localparam int DW      = 32;

  logic          i_clk, i_rst_n;
  logic          i_lsu_rdwen;
  logic [AW-1:0] i_lsu_rdid;
  logic [DW-1:0] i_lsu_rd;
  logic          o_lsu_stall;
  logic          i_mdu_valid, o_mdu_ready;
  logic [AW-1:0] i_mdu_rdid;
  logic [DW-1:0] i_mdu_rd;
  logic [AW-1:0] i_idu_rs1id, i_idu_rs2id;
  logic          o_idu_busy;
  logic          o_wbu_rdwen;
  logic [AW-1:0] o_wbu_rdid;
  logic [DW-1:0] o_wbu_rd;

  wbu_arb #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX), .REG_ADDRW(AW), .CPU_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_lsu_rdwen(i_lsu_rdwen), .i_lsu_rdid(i_lsu_rdid), .i_lsu_rd(i_lsu_rd),
    .o_lsu_stall(o_lsu_stall),
    .i_mdu_valid(i_mdu_valid), .o_mdu_ready(o_mdu_ready),
    .i_mdu_rdid(i_mdu_rdid), .i_mdu_rd(i_mdu_rd),
    .i_idu_rs1id(i_idu_rs1id), .i_idu_rs2id(i_idu_rs2id), .o_idu_busy(o_idu_busy),
    .o_wbu_rdwen(o_wbu_rdwen), .o_wbu_rdid(o_wbu_rdid), .o_wbu_rd(o_wbu_rd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the buffer is a queue of results, the regfile port a plain record.
  typedef struct {
    logic [AW-1:0] id;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            age;
  logic          m_wen;
  logic [AW-1:0] m_id;
  logic [DW-1:0] m_d;

  task automatic model_reset();
    q.delete();
    age   = 0;
    m_wen = 1'b0;
    m_id  = '0;
    m_d   = '0;
  endtask

  function automatic bit m_busy();
    foreach (q[k])
      if ((i_idu_rs1id != 0 && q[k].id == i_idu_rs1id) ||
          (i_idu_rs2id != 0 && q[k].id == i_idu_rs2id))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return (q.size() != 0) && (age == AGE_MAX);
  endfunction

  task automatic compare_outputs();
    check("mdu_ready", o_mdu_ready, q.size() < DEPTH);
    check("lsu_stall", o_lsu_stall, m_stall());
    check("idu_busy",  o_idu_busy,  m_busy());
    check("wbu_rdwen", o_wbu_rdwen, m_wen);
    check("wbu_rdid",  o_wbu_rdid,  m_id);
    check("wbu_rd",    o_wbu_rd,    m_d);
  endtask

  task automatic model_step();
    int sz;
    bit stall, lw, pop, push;
    sz    = q.size();
    stall = m_stall();
    lw    = i_lsu_rdwen && (i_lsu_rdid != 0) && !stall;
    pop   = (sz != 0) && !lw;
    push  = i_mdu_valid && (sz < DEPTH);
    if (lw) begin
      m_wen = 1'b1; m_id = i_lsu_rdid; m_d = i_lsu_rd;
    end else if (pop) begin
      m_wen = 1'b1; m_id = q[0].id; m_d = q[0].d;
    end else begin
      m_wen = 1'b0;
    end
    if (sz == 0 || pop) age = 0;
    else if (age < AGE_MAX) age = age + 1;
    if (pop) void'(q.pop_front());
    if (push && i_mdu_rdid != 0) q.push_back('{i_mdu_rdid, i_mdu_rd});
  endtask

  // One clock: compare mid-cycle, advance the model, then return just after the edge.
  task automatic cycle();
    @(negedge i_clk);
    compare_outputs();
    if (o_lsu_stall) stall_seen++;
    if (i_rst_n) model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic lw, input logic [AW-1:0] lid, input logic [DW-1:0] ld,
                       input logic mv, input logic [AW-1:0] mid, input logic [DW-1:0] md);
    i_lsu_rdwen = lw; i_lsu_rdid = lid; i_lsu_rd = ld;
    i_mdu_valid = mv; i_mdu_rdid = mid; i_mdu_rd = md;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_lsu_rdwen = 1'b0; i_lsu_rdid = '0; i_lsu_rd = '0;
    i_mdu_valid = 1'b0; i_mdu_rdid = '0; i_mdu_rd = '0;
    i_idu_rs1id = 5'd7; i_idu_rs2id = 5'd0;
    model_reset();
    #2;
    compare_outputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Pipeline only, then x0 destination
    drive(1'b1, 5'd5, 32'h11, 1'b0, '0, '0);
    drive(1'b1, 5'd0, 32'h22, 1'b0, '0, '0);
    idle(1);

    // Single MDU result with the pipeline idle
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hAB);
    idle(3);

    // Fill while the pipeline writes every cycle: forced stall drains the head
    i_idu_rs1id = 5'd3; i_idu_rs2id = 5'd4;
    stall_seen = 0;
    drive(1'b1, 5'd9, 32'h90, 1'b1, 5'd3, 32'h33);
    drive(1'b1, 5'd10, 32'h91, 1'b1, 5'd4, 32'h44);
    for (int k = 0; k < 5; k++) drive(1'b1, 5'(11 + k), 32'(32'h100 + k), 1'b0, '0, '0);
    check("fill_stall_count", stall_seen, 1);
    idle(6);

    // Back-to-back push/pop at occupancy one, wrapping the pointers
    drive(1'b0, '0, '0, 1'b1, 5'd1, 32'hC000);
    for (int k = 0; k < 10; k++) drive(1'b0, '0, '0, 1'b1, 5'(2 + k), 32'(32'hC001 + k));
    idle(3);

    // Reset with two entries buffered
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd3, 32'hD3);
    drive(1'b1, 5'd9, 32'h2, 1'b1, 5'd4, 32'hD4);
    i_lsu_rdwen = 1'b0; i_mdu_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    cycle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    idle(3);

    // x0 MDU result is acknowledged but never written
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hEE);
    idle(2);

    // Random traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      i_idu_rs1id = 5'($urandom_range(0, 7));
      i_idu_rs2id = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
